control_sequencer: RTL and testbench

//  Hardwired multi-cycle control unit replacing hand-sequenced T-state stimulus.

---
 rtl/ctrl_pkg.sv | 80 ++++++++
 rtl/ctrl_strobe_decode.sv | 76 +++++++
 rtl/control_sequencer.sv | 145 ++++++++++++++
 tb/tb_control_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for control_sequencer: opcodes, AluOp codes, T-state encodings,
// the strobe bundle and opcode classification helpers.
package ctrl_pkg;

  localparam int unsigned OP_LD   = 0;
  localparam int unsigned OP_LDI  = 1;
  localparam int unsigned OP_ST   = 2;
  localparam int unsigned OP_ADD  = 3;
  localparam int unsigned OP_SUB  = 4;
  localparam int unsigned OP_AND  = 5;
  localparam int unsigned OP_OR   = 6;
  localparam int unsigned OP_ADDI = 12;

  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_SUB = 1;
  localparam int unsigned ALU_AND = 2;
  localparam int unsigned ALU_OR  = 3;

  // T0_IDLE reports as T-state 0 on the debug bus; FAULT reports as 15.
  typedef enum logic [3:0] {
    T0      = 4'd0,
    T1      = 4'd1,
    T2      = 4'd2,
    T3      = 4'd3,
    T4      = 4'd4,
    T5      = 4'd5,
    T6      = 4'd6,
    T7      = 4'd7,
    T0_IDLE = 4'd8,
    FAULT   = 4'd15
  } state_e;

  typedef enum logic [2:0] {
    CL_LDI, CL_ADDI, CL_ALU, CL_LD, CL_ST, CL_ILL
  } op_class_e;

  typedef struct packed {
    logic pcout;
    logic zhiout;
    logic zlowout;
    logic mdrout;
    logic cout;
    logic baout;
    logic rout;
    logic marin;
    logic zin;
    logic pcin;
    logic mdrin;
    logic irin;
    logic yin;
    logic rin;
    logic gra;
    logic grb;
    logic grc;
    logic incpc;
    logic read;
    logic write;
  } strobes_t;

  function automatic op_class_e op_class(input logic [31:0] opc);
    case (opc)
      OP_LD:                          return CL_LD;
      OP_LDI:                         return CL_LDI;
      OP_ST:                          return CL_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR:  return CL_ALU;
      OP_ADDI:                        return CL_ADDI;
      default:                        return CL_ILL;
    endcase
  endfunction

  function automatic int unsigned alu_sel(input logic [31:0] opc);
    case (opc)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_strobe_decode.sv
// Combinational strobe decode: (state about to be entered, opcode) -> strobe bundle
// and ALU select. Registered by control_sequencer.
module ctrl_strobe_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPC_W    = 5,
  parameter int unsigned ALU_OP_W = 4
) (
  input  state_e              state_i,
  input  logic [OPC_W-1:0]    opc_i,
  output strobes_t            strobes_o,
  output logic [ALU_OP_W-1:0] alu_op_o
);

  op_class_e cls;
  logic      mem_op;

  assign cls    = op_class(32'(opc_i));
  assign mem_op = (cls == CL_LD) || (cls == CL_ST);

  always_comb begin
    strobes_o = '0;
    alu_op_o  = ALU_OP_W'(ALU_ADD);
    case (state_i)
      T0: begin
        strobes_o.pcout = 1'b1; strobes_o.marin = 1'b1;
        strobes_o.incpc = 1'b1; strobes_o.zin   = 1'b1;
      end
      T1: begin
        strobes_o.zlowout = 1'b1; strobes_o.pcin  = 1'b1;
        strobes_o.read    = 1'b1; strobes_o.mdrin = 1'b1;
      end
      T2: begin
        strobes_o.mdrout = 1'b1; strobes_o.irin = 1'b1;
      end
      T3: begin
        strobes_o.grb = 1'b1; strobes_o.yin = 1'b1;
        if (cls == CL_ADDI || cls == CL_ALU) strobes_o.rout  = 1'b1;
        else                                 strobes_o.baout = 1'b1;
      end
      T4: begin
        strobes_o.zin = 1'b1;
        if (cls == CL_ALU) begin
          strobes_o.grc = 1'b1; strobes_o.rout = 1'b1;
          alu_op_o      = ALU_OP_W'(alu_sel(32'(opc_i)));
        end else begin
          strobes_o.cout = 1'b1;
        end
      end
      T5: begin
        strobes_o.zlowout = 1'b1;
        if (mem_op) strobes_o.marin = 1'b1;
        else begin
          strobes_o.gra = 1'b1; strobes_o.rin = 1'b1;
        end
      end
      T6: begin
        strobes_o.mdrin = 1'b1;
        if (cls == CL_ST) begin
          strobes_o.gra = 1'b1; strobes_o.rout = 1'b1;
        end else begin
          strobes_o.read = 1'b1;
        end
      end
      T7: begin
        strobes_o.mdrout = 1'b1;
        if (cls == CL_ST) strobes_o.write = 1'b1;
        else begin
          strobes_o.gra = 1'b1; strobes_o.rin = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: fetch T0-T2, per-opcode execute T3-T7, with
// registered strobes decoded from next state. SEQ_TIMEOUT_EN enables the MemReady wait timeout.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned OPC_W       = 5,
  parameter int unsigned ALU_OP_W    = 4,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                Run,
  input  logic [OPC_W-1:0]    IRopc,
  input  logic                MemReady,
  output logic                PCout,
  output logic                Zhiout,
  output logic                Zlowout,
  output logic                MDRout,
  output logic                Cout,
  output logic                BAout,
  output logic                Rout,
  output logic                MARin,
  output logic                Zin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                Rin,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                IncPC,
  output logic                Read,
  output logic                Write,
  output logic [ALU_OP_W-1:0] AluOp,
  output logic [3:0]          Tstate,
  output logic                Halted,
  output logic                Fault
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 15) begin : g_bad_timeout
    $error("TIMEOUT_CYC must fit the 4-bit wait counter");
  end

  state_e              state_q, state_d, fetch_next;
  op_class_e           cls;
  strobes_t            strb_d, strb_q;
  logic [ALU_OP_W-1:0] alu_d, alu_q;
  logic [3:0]          tstate_q;
  logic                halted_q, fault_q;
  logic                waiting, timeout;

  assign cls     = op_class(32'(IRopc));
  assign waiting = (state_q == T1) ||
                   (state_q == T6 && cls == CL_LD) ||
                   (state_q == T7 && cls == CL_ST);
  // Strobes are decided on entry to a state, so Run is sampled on the edge into T0.
  assign fetch_next = Run ? T0 : T0_IDLE;

`ifdef SEQ_TIMEOUT_EN
  logic [3:0] wait_q, wait_d;
  assign wait_d  = (waiting && !MemReady) ? wait_q + 4'd1 : '0;
  assign timeout = waiting && !MemReady && (wait_q == 4'(TIMEOUT_CYC - 1));
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) wait_q <= '0;
    else        wait_q <= wait_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      T0_IDLE: state_d = fetch_next;
      T0:      state_d = T1;
      T1:      if (MemReady) state_d = T2;
               else if (timeout) state_d = FAULT;
      T2:      state_d = (cls == CL_ILL) ? FAULT : T3;
      T3:      state_d = T4;
      T4:      state_d = T5;
      T5:      state_d = (cls == CL_LD || cls == CL_ST) ? T6 : fetch_next;
      T6:      if (!waiting || MemReady) state_d = T7;
               else if (timeout) state_d = FAULT;
      T7:      if (!waiting || MemReady) state_d = fetch_next;
               else if (timeout) state_d = FAULT;
      FAULT:   state_d = FAULT;
      default: state_d = T0_IDLE;
    endcase
  end

  ctrl_strobe_decode #(
    .OPC_W    (OPC_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_decode (
    .state_i   (state_d),
    .opc_i     (IRopc),
    .strobes_o (strb_d),
    .alu_op_o  (alu_d)
  );

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q  <= T0_IDLE;
      strb_q   <= '0;
      alu_q    <= ALU_OP_W'(ALU_ADD);
      tstate_q <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      strb_q   <= strb_d;
      alu_q    <= alu_d;
      tstate_q <= (state_d == T0_IDLE) ? 4'd0 : 4'(state_d);
      halted_q <= (state_d == T0_IDLE) || (state_d == FAULT);
      fault_q  <= (state_d == FAULT);
    end
  end

  assign PCout   = strb_q.pcout;
  assign Zhiout  = strb_q.zhiout;
  assign Zlowout = strb_q.zlowout;
  assign MDRout  = strb_q.mdrout;
  assign Cout    = strb_q.cout;
  assign BAout   = strb_q.baout;
  assign Rout    = strb_q.rout;
  assign MARin   = strb_q.marin;
  assign Zin     = strb_q.zin;
  assign PCin    = strb_q.pcin;
  assign MDRin   = strb_q.mdrin;
  assign IRin    = strb_q.irin;
  assign Yin     = strb_q.yin;
  assign Rin     = strb_q.rin;
  assign Gra     = strb_q.gra;
  assign Grb     = strb_q.grb;
  assign Grc     = strb_q.grc;
  assign IncPC   = strb_q.incpc;
  assign Read    = strb_q.read;
  assign Write   = strb_q.write;
  assign AluOp   = alu_q;
  assign Tstate  = tstate_q;
  assign Halted  = halted_q;
  assign Fault   = fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-opcode step tables expanded with
// randomized MemReady waits, compared against the DUT every cycle.
module tb_control_sequencer;

  logic       Clock = 1'b0;
  logic       Clear = 1'b0;
  logic       Run = 1'b0;
  logic       MemReady = 1'b0;
  logic [4:0] IRopc = '0;
  logic PCout, Zhiout, Zlowout, MDRout, Cout, BAout, Rout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, Rin;
  logic Gra, Grb, Grc, IncPC, Read, Write;
  logic [3:0] AluOp;
  logic [3:0] Tstate;
  logic Halted, Fault;

  control_sequencer #(
    .OPC_W       (5),
    .ALU_OP_W    (4),
    .TIMEOUT_CYC (15)
  ) dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .IRopc(IRopc), .MemReady(MemReady),
    .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
    .BAout(BAout), .Rout(Rout), .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .Rin(Rin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC),
    .Read(Read), .Write(Write), .AluOp(AluOp), .Tstate(Tstate), .Halted(Halted), .Fault(Fault)
  );

  always #5 Clock = ~Clock;

  logic [19:0] obs;
  assign obs = {Write, Read, IncPC, Grc, Grb, Gra, Rin, Yin, IRin, MDRin,
                PCin, Zin, MARin, Rout, BAout, Cout, MDRout, Zlowout, Zhiout, PCout};

  localparam logic [19:0] PCO = 20'h00001, ZLO = 20'h00004, MDO = 20'h00008, CO  = 20'h00010,
                          BAO = 20'h00020, RO  = 20'h00040, MAI = 20'h00080, ZIN = 20'h00100,
                          PCI = 20'h00200, MDI = 20'h00400, IRI = 20'h00800, YIN = 20'h01000,
                          RIN = 20'h02000, GRA = 20'h04000, GRB = 20'h08000, GRC = 20'h10000,
                          INC = 20'h20000, RD  = 20'h40000, WR  = 20'h80000;

  typedef struct {
    logic [19:0] m;
    logic [3:0]  alu;
    logic [3:0]  t;
    bit          wt;
    int          w;
  } step_t;

  int unsigned n_pass = 0, n_chk = 0;
  int unsigned cyc = 0, t0_cyc = 0, last_len = 0, fault_at = 0;
  int legal[8] = '{0, 1, 2, 3, 4, 5, 6, 12};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_reset_zero(input string name);
    check({name, "_strobes"}, obs, 0);
    check({name, "_aluop"}, AluOp, 0);
    check({name, "_tstate"}, Tstate, 0);
    check({name, "_halted"}, Halted, 0);
    check({name, "_fault"}, Fault, 0);
  endtask

  // Check the current cycle's outputs, then drive this cycle's inputs.
  task automatic step(input logic [19:0] em, input logic [3:0] ealu, input logic [3:0] et,
                      input bit cht, input bit eh, input bit ef,
                      input bit rn, input bit mr, input logic [4:0] op);
    @(negedge Clock);
    cyc++;
    check("strobes", obs, em);
    check("aluop", AluOp, ealu);
    if (cht) check("tstate", Tstate, et);
    check("halted", Halted, eh);
    check("fault", Fault, ef);
    check("bus_onehot", ($countones(obs[6:0]) <= 1), 1);
    check("rd_wr_excl", Read & Write, 0);
    if (PCout) begin
      last_len = cyc - t0_cyc;
      t0_cyc   = cyc;
    end
    if (Fault === 1'b1 && fault_at == 0) fault_at = cyc - t0_cyc + 1;
    Run      = rn;
    MemReady = mr;
    IRopc    = op;
  endtask

  task automatic instr(input int opc, input int w1, input int wx, input bit run_end,
                       input int stop_cyc);
    step_t s[$];
    bit ld, st, alu, addi, legal_op;
    int n;
    ld   = (opc == 0);
    st   = (opc == 2);
    alu  = (opc >= 3 && opc <= 6);
    addi = (opc == 12);
    legal_op = ld || st || alu || addi || (opc == 1);
    n = 0;
    s.push_back('{PCO | MAI | INC | ZIN, 4'd0, 4'd0, 1'b0, 0});
    s.push_back('{ZLO | PCI | RD | MDI, 4'd0, 4'd1, 1'b1, w1});
    s.push_back('{MDO | IRI, 4'd0, 4'd2, 1'b0, 0});
    if (legal_op) begin
      s.push_back('{(addi || alu) ? (GRB | RO | YIN) : (GRB | BAO | YIN), 4'd0, 4'd3, 1'b0, 0});
      if (alu) s.push_back('{GRC | RO | ZIN, 4'(opc - 3), 4'd4, 1'b0, 0});
      else     s.push_back('{CO | ZIN, 4'd0, 4'd4, 1'b0, 0});
      s.push_back('{(ld || st) ? (ZLO | MAI) : (ZLO | GRA | RIN), 4'd0, 4'd5, 1'b0, 0});
      if (ld) begin
        s.push_back('{RD | MDI, 4'd0, 4'd6, 1'b1, wx});
        s.push_back('{MDO | GRA | RIN, 4'd0, 4'd7, 1'b0, 0});
      end
      if (st) begin
        s.push_back('{GRA | RO | MDI, 4'd0, 4'd6, 1'b0, 0});
        s.push_back('{MDO | WR, 4'd0, 4'd7, 1'b1, wx});
      end
    end
    foreach (s[i]) begin
      int reps;
      bit to;
      reps = s[i].wt ? s[i].w + 1 : 1;
      to   = 1'b0;
`ifdef SEQ_TIMEOUT_EN
      if (s[i].wt && s[i].w >= 15) begin
        reps = 15;
        to   = 1'b1;
      end
`endif
      for (int r = 0; r < reps; r++) begin
        bit mr, rn;
        mr = s[i].wt ? (!to && r == s[i].w) : bit'($urandom_range(0, 1));
        rn = (i == s.size() - 1 && r == reps - 1) ? run_end : bit'($urandom_range(0, 1));
        step(s[i].m, s[i].alu, s[i].t, 1'b1, 1'b0, 1'b0, rn, mr, 5'(opc));
        n++;
        if (stop_cyc != 0 && n == stop_cyc) return;
      end
      if (to) return;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      step('0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, (k == n - 1), bit'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)));
  endtask

  task automatic fault_cycles(input int n);
    for (int k = 0; k < n; k++)
      step('0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
  endtask

  task automatic clear_pulse();
    @(negedge Clock);
    cyc++;
    Clear = 1'b0;
    #1;
    check_reset_zero("async_clear");
    @(negedge Clock);
    cyc++;
    check_reset_zero("held_in_reset");
    Clear    = 1'b1;
    Run      = 1'b1;
    MemReady = bit'($urandom_range(0, 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int op;
    bit re;
    repeat (2) @(negedge Clock);
    check_reset_zero("reset");
    Clear = 1'b1;
    Run   = 1'b0;

    idle(3);
    instr(1, 0, 0, 1'b1, 0);
    instr(0, 0, 3, 1'b1, 0);
    check("ldi_cycles", last_len, 6);
    instr(2, 1, 2, 1'b0, 0);
    check("ld_wait3_cycles", last_len, 11);
    idle(4);
    for (int o = 3; o <= 6; o++) instr(o, $urandom_range(0, 2), 0, 1'b1, 0);
    instr(12, 0, 0, 1'b1, 0);

    fault_at = 0;
    instr(31, 0, 0, 1'b1, 0);
    fault_cycles(5);
    check("fault_first_cycle", fault_at, 4);
    clear_pulse();

    instr(0, 0, 5, 1'b1, 8);
    clear_pulse();

`ifdef SEQ_TIMEOUT_EN
    instr(0, 0, 20, 1'b1, 0);
    fault_cycles(3);
    clear_pulse();
`endif

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        op = $urandom_range(7, 31);
        if (op == 12) op = 13;
        instr(op, $urandom_range(0, 4), 0, 1'b1, 0);
        fault_cycles($urandom_range(1, 4));
        clear_pulse();
      end else begin
        re = ($urandom_range(0, 3) != 0);
        instr(legal[$urandom_range(0, 7)], $urandom_range(0, 4), $urandom_range(0, 4), re, 0);
        if (!re) idle($urandom_range(1, 3));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
